// File: rtl/pista_pkg.sv
// Shared types and constants for the racing-track scroll controller.
package pista_pkg;

  localparam int ROW_W     = 8;
  localparam int WIN_DEPTH = 8;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [1:0]       level_t;

  localparam level_t SPEED_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CRASH = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pista_scroll_ctrl_if.sv
// Track-row request/valid handshake between the scroll controller (master)
// and the track-row source (slave).
interface pista_scroll_ctrl_if;
  import pista_pkg::*;

  logic ROW_REQ;
  row_t ROW_IN;
  logic ROW_VALID;

  modport master (output ROW_REQ, input ROW_IN, input ROW_VALID);
  modport slave  (input ROW_REQ, output ROW_IN, output ROW_VALID);
endinterface

// File: rtl/pista_tick_gen.sv
// Scroll prescaler: counts enabled cycles up to (TICK_DIV >> level) - 1 and
// emits a one-cycle tick there, clearing itself on the tick or on clr.
module pista_tick_gen
  import pista_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int          DIV_W    = 16
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   en,
  input  logic   clr,
  input  level_t level,
  output logic   tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  assign period = DIV_W'(TICK_DIV >> level);
  assign tick   = en && (cnt == period - ONE);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of process ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pista_scroll_ctrl.sv
// Track scroll controller: FSM, row handshake, 8-row window, collision, score.
// Optional SCROLL_SPEEDUP_EN: scroll period halves every 32 RUN rows, up to 3 times.
module pista_scroll_ctrl
  import pista_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int          DIV_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [2:0]                 CAR_POS,
  pista_scroll_ctrl_if.master        row,
  input  logic [2:0]                 WIN_SEL,
  output row_t                       WIN_ROW,
  output logic                       CRASH,
  output logic [1:0]                 STATE,
  output logic [7:0]                 SCORE
);

  state_t     state, state_d;
  logic       row_req, row_req_d;
  row_t       window [WIN_DEPTH];
  logic [2:0] fill_cnt;
  logic [7:0] score;
  level_t     level;
  logic       tick;
  logic       crash_det;
  logic       accept;
  logic       start_game;

  assign crash_det  = (state == ST_RUN) && window[WIN_DEPTH-1][CAR_POS];
  // A request still open when the car hits the wall is abandoned, not accepted.
  assign accept     = row_req && row.ROW_VALID && !crash_det;
  assign start_game = START && ((state == ST_IDLE) || (state == ST_CRASH));

  pista_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .en    ((state == ST_RUN) && !row_req),
    .clr   (state != ST_RUN),
    .level (level),
    .tick  (tick)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    row_req_d = row_req;
    unique case (state)
      ST_IDLE: begin
        if (START) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept) begin
          row_req_d = 1'b0;
          if (fill_cnt == 3'd7) state_d = ST_RUN;
        end else begin
          row_req_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (crash_det) begin
          state_d   = ST_CRASH;
          row_req_d = 1'b0;
        end else if (accept) begin
          row_req_d = 1'b0;
        end else if (tick) begin
          row_req_d = 1'b1;
        end
      end
      ST_CRASH: begin
        row_req_d = 1'b0;
        if (START) state_d = ST_FILL;
      end
      default: begin
        state_d   = ST_IDLE;
        row_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      row_req <= 1'b0;
    end else begin
      state   <= state_d;
      row_req <= row_req_d;
    end
  end

  // NOTE: the window is reset row by row; the display reads it straight out
  // of reset, so it must not come up holding arbitrary contents.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < WIN_DEPTH; i++) window[i] <= '0;
      fill_cnt <= '0;
      score    <= '0;
    end else if (start_game) begin
      for (int i = 0; i < WIN_DEPTH; i++) window[i] <= '0;
      fill_cnt <= '0;
      score    <= '0;
    end else if (accept) begin
      for (int i = WIN_DEPTH - 1; i > 0; i--) window[i] <= window[i-1];
      window[0] <= row.ROW_IN;
      if (state == ST_FILL) fill_cnt <= fill_cnt + 3'd1;
      if (state == ST_RUN)  score    <= sat_inc8(score);
    end
  end

`ifdef SCROLL_SPEEDUP_EN
  // Level steps when an accepted row wraps SCORE[4:0] back to zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      level <= '0;
    end else if (start_game) begin
      level <= '0;
    end else if (accept && (state == ST_RUN) && (score != 8'hFF) &&
                 (score[4:0] == 5'h1F) && (level != SPEED_MAX)) begin
      level <= level + 2'd1;
    end
  end
`else
  assign level = '0;
`endif

  assign row.ROW_REQ = row_req;
  assign WIN_ROW     = window[WIN_SEL];
  assign CRASH       = (state == ST_CRASH);
  assign STATE       = state;
  assign SCORE       = score;

endmodule

// File: tb/tb_pista_scroll_ctrl.sv
// Directed bench for pista_scroll_ctrl: a scoreboard queue holds the expected
// window row and score for each served row and is drained when the row lands.
module tb_pista_scroll_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] CAR_POS;
  logic [2:0] WIN_SEL;
  logic [7:0] WIN_ROW;
  logic       CRASH;
  logic [1:0] STATE;
  logic [7:0] SCORE;

  pista_scroll_ctrl_if rif ();

  pista_scroll_ctrl #(
    .TICK_DIV (8),
    .DIV_W    (16)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .CAR_POS (CAR_POS),
    .row     (rif),
    .WIN_SEL (WIN_SEL),
    .WIN_ROW (WIN_ROW),
    .CRASH   (CRASH),
    .STATE   (STATE),
    .SCORE   (SCORE)
  );

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] score;
    logic       run;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] m_win [8];
  logic [7:0] m_score;
  int         m_level;
  int         checks;
  int         errors;
  int         cyc;
  int         last_rise;
  int         exp_space;
  int         start_cyc;

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_win(input string tag);
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      WIN_SEL = 3'(i);
      #1;
      check(tag, WIN_ROW, m_win[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_win[i] = 8'h00;
    m_score = 8'd0;
    m_level = 0;
  endtask

  // Acts as the track-row source: waits for ROW_REQ, answers after lat cycles.
  task automatic serve_row(input logic [7:0] data, input int lat, input bit in_run,
                           input bit chk_sp);
    int   n;
    exp_t e;
    n = 0;
    while (rif.ROW_REQ !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("row_req_rise", rif.ROW_REQ, 1);
    if (chk_sp) check("req_spacing", cyc - last_rise, exp_space);
    last_rise = cyc;
    for (int k = 0; k < lat; k++) @(negedge CLK);
    rif.ROW_IN    = data;
    rif.ROW_VALID = 1'b1;
    for (int i = 7; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = data;
    if (in_run) begin
      if (m_score != 8'hFF) m_score = m_score + 8'd1;
`ifdef SCROLL_SPEEDUP_EN
      m_level = (m_score >= 8'd96) ? 3 : int'(m_score) / 32;
`else
      m_level = 0;
`endif
    end
    sb_q.push_back('{row: data, score: m_score, run: in_run});
    @(negedge CLK);
    rif.ROW_VALID = 1'b0;
    rif.ROW_IN    = 8'hFF;
    check("row_req_drop", rif.ROW_REQ, 0);
    e = sb_q.pop_front();
    WIN_SEL = 3'd0;
    #1;
    check("win_top", WIN_ROW, e.row);
    WIN_SEL = 3'd7;
    #1;
    check("win_bottom", WIN_ROW, m_win[7]);
    if (e.run) check("score", SCORE, e.score);
    exp_space = lat + 1 + (8 >> m_level);
  endtask

  task automatic do_fill(input logic [7:0] data);
    for (int r = 0; r < 8; r++) serve_row(data, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    last_rise     = 0;
    exp_space     = 0;
    start_cyc     = 0;
    RESET         = 1'b1;
    START         = 1'b0;
    CAR_POS       = 3'd3;
    WIN_SEL       = 3'd0;
    rif.ROW_IN    = 8'h00;
    rif.ROW_VALID = 1'b0;
    clear_model();

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_state", STATE, 0);
    check("rst_req", rif.ROW_REQ, 0);
    check("rst_score", SCORE, 0);
    check("rst_crash", CRASH, 0);
    RESET = 1'b0;
    check_all_win("rst_win");

    // IDLE ignores ROW_VALID since no request is open
    @(negedge CLK);
    rif.ROW_VALID = 1'b1;
    rif.ROW_IN    = 8'hFF;
    repeat (3) @(negedge CLK);
    rif.ROW_VALID = 1'b0;
    check("idle_state", STATE, 0);
    check("idle_req", rif.ROW_REQ, 0);
    check_all_win("idle_win");

    // Fill with zero-latency source
    pulse_start();
    check("fill_state", STATE, 1);
    do_fill(8'h81);
    check("fill_cycles", cyc - start_cyc, 16);
    check("fill_run", STATE, 2);
    check("fill_score", SCORE, 0);
    check_all_win("fill_win");

    // Scroll rate: latency 3 gives 8 + 3 + 1 cycle spacing
    serve_row(8'h81, 3, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) serve_row(8'h81, 3, 1'b1, 1'b1);
    check("scroll_crash", CRASH, 0);

    // Crash on shift: 8'h89 walks down to the bottom row under CAR_POS 3
    serve_row(8'h89, 0, 1'b1, 1'b1);
    for (int r = 0; r < 7; r++) serve_row(8'h81, 0, 1'b1, 1'b1);
    check("shift_precrash", CRASH, 0);
    @(negedge CLK);
    check("shift_crash", CRASH, 1);
    check("shift_state", STATE, 3);
    check("shift_req", rif.ROW_REQ, 0);
    rif.ROW_VALID = 1'b1;
    rif.ROW_IN    = 8'hFF;
    repeat (4) @(negedge CLK);
    rif.ROW_VALID = 1'b0;
    check("frozen_score", SCORE, 12);
    check("frozen_req", rif.ROW_REQ, 0);
    check("frozen_state", STATE, 3);
    check_all_win("frozen_win");

    // Restart from CRASH, then a long run for speed-up and score saturation
    pulse_start();
    clear_model();
    check("restart_state", STATE, 1);
    check("restart_score", SCORE, 0);
    check("restart_crash", CRASH, 0);
    check_all_win("restart_win");
    do_fill(8'h81);
    serve_row(8'h81, 0, 1'b1, 1'b0);
    for (int r = 1; r < 256; r++) serve_row(8'h81, 0, 1'b1, 1'b1);
    check("score_sat", SCORE, 8'hFF);

    // Crash on steer: bottom row 8'h81, car moves from column 3 to 0
    CAR_POS = 3'd0;
    #1;
    check("steer_precrash", CRASH, 0);
    @(negedge CLK);
    check("steer_crash", CRASH, 1);
    check("steer_state", STATE, 3);
    check("steer_req", rif.ROW_REQ, 0);
    CAR_POS = 3'd3;
    pulse_start();
    clear_model();
    check("steer_restart_state", STATE, 1);
    check("steer_restart_score", SCORE, 0);

    // Reset in the middle of RUN with a request outstanding
    do_fill(8'h81);
    serve_row(8'h81, 0, 1'b1, 1'b0);
    n = 0;
    while (rif.ROW_REQ !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("midrun_req_open", rif.ROW_REQ, 1);
    check("midrun_score", SCORE, 1);
    #1 RESET = 1'b1;
    #1;
    check("async_req", rif.ROW_REQ, 0);
    check("async_state", STATE, 0);
    check("async_score", SCORE, 0);
    check("async_crash", CRASH, 0);
    clear_model();
    check_all_win("async_win");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_state", STATE, 0);
    check("post_rst_req", rif.ROW_REQ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
